// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared definitions for the FIFO drain controller: FSM encoding and
// default parameter values.
package fifo_drain_ctrl_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 4;
    localparam int unsigned DEF_READ_LATENCY = 5;
    localparam int unsigned DEF_BUF_DEPTH    = 8;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH_WAIT = 2'd1,
        FLUSH_CLR  = 2'd2
    } drain_state_e;

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// Output stream handshake of the drain controller (valid/ready/data).
interface fifo_drain_ctrl_if #(
    parameter int unsigned DATA_WIDTH = fifo_drain_ctrl_pkg::DEF_DATA_WIDTH
);

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/fifo_drain_ctrl_landing_buf.sv
// Landing buffer: circular store for returned read data with a registered
// head entry, synchronous clear and occupancy count.
module drain_landing_buf
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BUF_DEPTH  = DEF_BUF_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             wr_en,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             pop,
    output logic [DATA_WIDTH-1:0]            head,
    output logic [$clog2(BUF_DEPTH):0]       occupancy
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      rd_ptr_nxt;
    logic [OCC_W-1:0]      count;
    logic [OCC_W-1:0]      remain;

    always_comb begin
        rd_ptr_nxt = rd_ptr + PTR_W'(pop);
        remain     = count - OCC_W'(pop);
    end

    // head tracks the entry at the next read pointer; when the buffer would
    // otherwise be empty, the word being written becomes the new head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= remain + OCC_W'(wr_en);
            if (remain != '0) begin
                head <= mem[rd_ptr_nxt];
            end else if (wr_en) begin
                head <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign occupancy = count;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains an upstream fixed-latency FIFO into a valid/ready stream, using
// credit-limited reads so the landing buffer can never overflow.
module fifo_drain_ctrl
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
    parameter int unsigned BUF_DEPTH    = DEF_BUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  drain_en,
    input  logic                  flush,
    input  logic                  fifo_empty,
    output logic                  fifo_read_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    fifo_drain_ctrl_if.master     out,
    output logic                  flush_done,
    output logic                  busy
);

    localparam int unsigned INF_W = $clog2(READ_LATENCY + 1);
    localparam int unsigned OCC_W = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned SUM_W = OCC_W + 1;

    drain_state_e          state;
    drain_state_e          state_nxt;
    logic [READ_LATENCY-1:0] tag;
    logic [INF_W-1:0]      inflight;
    logic [OCC_W-1:0]      occupancy;
    logic [SUM_W-1:0]      credit_sum;
    logic                  credit_ok;
    logic                  capture;
    logic                  pop;
    logic                  buf_clear;
    logic                  valid;
    logic [DATA_WIDTH-1:0] head;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + INF_W'(tag[i]);
        end
        credit_sum = SUM_W'(inflight) + SUM_W'(occupancy);
        credit_ok  = credit_sum < SUM_W'(BUF_DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fifo_read_en = 1'b0;
        capture      = 1'b0;
        valid        = 1'b0;
        buf_clear    = 1'b0;
        flush_done   = 1'b0;
        unique case (state)
            RUN: begin
                fifo_read_en = drain_en && !fifo_empty && credit_ok;
                capture      = tag[READ_LATENCY-1];
                valid        = occupancy != '0;
                if (flush) begin
                    state_nxt = FLUSH_WAIT;
                end
            end
            FLUSH_WAIT: begin
                if (inflight == '0) begin
                    state_nxt = FLUSH_CLR;
                end
            end
            FLUSH_CLR: begin
                buf_clear  = 1'b1;
                flush_done = 1'b1;
                state_nxt  = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Tag pipeline mirrors the upstream read latency; the last stage marks
    // the cycle in which fifo_data carries a requested word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag <= '0;
        end else begin
            tag[0] <= fifo_read_en;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                tag[i] <= tag[i-1];
            end
        end
    end

    assign pop  = valid && out.out_ready;
    assign busy = (inflight != '0) || (occupancy != '0);

    drain_landing_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_landing_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (buf_clear),
        .wr_en     (capture),
        .wr_data   (fifo_data),
        .pop       (pop),
        .head      (head),
        .occupancy (occupancy)
    );

    assign out.out_valid = valid;
    assign out.out_data  = head;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Scoreboard bench for fifo_drain_ctrl: an upstream FIFO model with fixed
// read latency feeds the DUT and predicts the ordered output stream.
module tb_fifo_drain_ctrl;
    import fifo_drain_ctrl_pkg::*;

    localparam int unsigned DW = 4;
    localparam int unsigned L  = 5;
    localparam int unsigned D  = 8;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic          drain_en   = 1'b0;
    logic          flush      = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_read_en;
    logic [DW-1:0] fifo_data  = '0;
    logic          flush_done;
    logic          busy;

    fifo_drain_ctrl_if #(.DATA_WIDTH(DW)) ifc ();

    fifo_drain_ctrl #(
        .DATA_WIDTH   (DW),
        .READ_LATENCY (L),
        .BUF_DEPTH    (D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .drain_en     (drain_en),
        .flush        (flush),
        .fifo_empty   (fifo_empty),
        .fifo_read_en (fifo_read_en),
        .fifo_data    (fifo_data),
        .out          (ifc),
        .flush_done   (flush_done),
        .busy         (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int delivered = 0;
    int reads     = 0;
    int valid_cnt = 0;
    int first_read_cyc  = -1;
    int first_valid_cyc = -1;
    int last_read_cyc   = -100;
    int done_exp_cyc    = -1;
    logic empty_mask = 1'b0;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];
    logic [DW-1:0] pd [L];
    logic [DW-1:0] rd_word;
    logic          rd_pending = 1'b0;

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by time %0t, expected finish earlier", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n, input bit rnd, input int start);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(rnd ? DW'($urandom) : DW'(start + i));
        end
    endtask

    task automatic wait_deliver(input string name, input int target, input int budget);
        for (int i = 0; i < budget && delivered < target; i++) cycle();
        chk(name, delivered, target);
    endtask

    // Upstream FIFO: a word popped on a read is presented READ_LATENCY cycles later.
    initial begin : upstream
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                fifo_q.delete();
                rd_pending = 1'b0;
                for (int i = 0; i < L; i++) pd[i] = DW'($urandom);
            end else begin
                for (int i = L - 1; i > 0; i--) pd[i] = pd[i-1];
                pd[0] = rd_pending ? rd_word : DW'($urandom);
                rd_pending = 1'b0;
            end
            fifo_data  = pd[L-1];
            fifo_empty = (fifo_q.size() == 0) || empty_mask;
            @(negedge clk);
            if (rst_n && fifo_read_en) begin
                chk("read_while_empty", int'(fifo_empty), 0);
                if (fifo_q.size() != 0) begin
                    rd_word    = fifo_q.pop_front();
                    rd_pending = 1'b1;
                    exp_q.push_back(rd_word);
                    reads++;
                    last_read_cyc = cyc;
                    if (first_read_cyc < 0) first_read_cyc = cyc;
                end
            end
        end
    end

    initial begin : monitor
        logic          stall_prev;
        logic          flush_prev;
        logic [DW-1:0] data_prev;
        logic [DW-1:0] w;
        stall_prev = 1'b0;
        flush_prev = 1'b0;
        data_prev  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
                flush_prev = 1'b0;
            end else begin
                if (stall_prev && !flush_prev) begin
                    chk("stall_valid", int'(ifc.out_valid), 1);
                    chk("stall_data", int'(ifc.out_data), int'(data_prev));
                end
                if (ifc.out_valid) begin
                    valid_cnt++;
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                end
                if (ifc.out_valid && ifc.out_ready) begin
                    chk("pop_expected", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        w = exp_q.pop_front();
                        chk("out_data", int'(ifc.out_data), int'(w));
                        delivered++;
                    end
                end
                if (flush_done) begin
                    chk("flush_done_cycle", cyc, done_exp_cyc);
                    done_exp_cyc = -1;
                end else if (done_exp_cyc >= 0 && cyc > done_exp_cyc) begin
                    chk("flush_done_missing", int'(flush_done), 1);
                    done_exp_cyc = -1;
                end
                stall_prev = ifc.out_valid && !ifc.out_ready;
                data_prev  = ifc.out_data;
                flush_prev = flush;
            end
        end
    end

    initial begin : driver
        int t;
        int f;
        int r0;
        int d0;
        int v0;
        ifc.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(ifc.out_valid), 0);
        chk("rst_out_data", int'(ifc.out_data), 0);
        chk("rst_flush_done", int'(flush_done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_read_en", int'(fifo_read_en), 0);
        cycle();
        rst_n = 1'b1;

        // Ordered words 1..4 and issue-to-valid latency
        first_read_cyc  = -1;
        first_valid_cyc = -1;
        push_words(4, 1'b0, 1);
        drain_en = 1'b1;
        ifc.out_ready = 1'b1;
        wait_deliver("ordered4_count", 4, 100);
        chk("first_out_latency", first_valid_cyc - first_read_cyc, L + 1);

        // Credit limit with a stalled output
        ifc.out_ready = 1'b0;
        r0 = reads;
        d0 = delivered;
        push_words(12, 1'b1, 0);
        repeat (30) cycle();
        chk("credit_reads", reads - r0, D);
        @(negedge clk);
        chk("credit_read_en_low", int'(fifo_read_en), 0);
        cycle();
        ifc.out_ready = 1'b1;
        wait_deliver("credit_all_delivered", d0 + 12, 200);
        chk("credit_total_reads", reads - r0, 12);

        // fifo_empty toggling every cycle
        r0 = reads;
        d0 = delivered;
        push_words(10, 1'b1, 0);
        for (int i = 0; i < 300 && delivered < d0 + 10; i++) begin
            cycle();
            empty_mask = !empty_mask;
        end
        empty_mask = 1'b0;
        chk("toggle_delivered", delivered - d0, 10);
        chk("toggle_reads_eq_out", reads - r0, delivered - d0);

        // Flush with three reads in flight and two words buffered
        ifc.out_ready = 1'b0;
        drain_en = 1'b0;
        repeat (3) cycle();
        first_read_cyc = -1;
        d0 = delivered;
        push_words(5, 1'b1, 0);
        drain_en = 1'b1;
        for (int i = 0; i < 50 && first_read_cyc < 0; i++) cycle();
        chk("flush_setup_read", int'(first_read_cyc >= 0), 1);
        f = first_read_cyc;
        for (int i = 0; i < 50 && cyc < f + int'(L) + 2; i++) cycle();
        flush = 1'b1;
        drain_en = 1'b0;
        t = cyc;
        cycle();
        flush = 1'b0;
        done_exp_cyc = (t + 2 > last_read_cyc + int'(L) + 2) ? t + 2 : last_read_cyc + int'(L) + 2;
        exp_q.delete();
        ifc.out_ready = 1'b1;
        @(negedge clk);
        chk("flush_valid_low", int'(ifc.out_valid), 0);
        repeat (15) cycle();
        chk("flush_done_seen", done_exp_cyc, -1);
        @(negedge clk);
        chk("flush_busy_low", int'(busy), 0);
        chk("flush_nothing_out", delivered, d0);
        cycle();
        d0 = delivered;
        push_words(3, 1'b1, 0);
        drain_en = 1'b1;
        wait_deliver("post_flush_delivered", d0 + 3, 100);

        // Idle flush, held into FLUSH_WAIT and FLUSH_CLR where it must be ignored
        repeat (3) cycle();
        flush = 1'b1;
        t = cyc;
        cycle();
        done_exp_cyc = (t + 2 > last_read_cyc + int'(L) + 2) ? t + 2 : last_read_cyc + int'(L) + 2;
        exp_q.delete();
        cycle();
        cycle();
        flush = 1'b0;
        repeat (6) cycle();
        chk("idle_flush_done_seen", done_exp_cyc, -1);

        // Reset mid-stream with four reads in flight
        first_read_cyc = -1;
        ifc.out_ready = 1'b1;
        push_words(10, 1'b1, 0);
        drain_en = 1'b1;
        for (int i = 0; i < 50 && first_read_cyc < 0; i++) cycle();
        f = first_read_cyc;
        for (int i = 0; i < 50 && cyc < f + 4; i++) cycle();
        rst_n = 1'b0;
        drain_en = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", int'(ifc.out_valid), 0);
        chk("midrst_out_data", int'(ifc.out_data), 0);
        chk("midrst_flush_done", int'(flush_done), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_read_en", int'(fifo_read_en), 0);
        repeat (2) cycle();
        rst_n = 1'b1;
        v0 = valid_cnt;
        repeat (20) cycle();
        chk("midrst_no_spurious_valid", valid_cnt - v0, 0);

        // Random backpressure, empty gaps and drain_en over 200 words
        d0 = delivered;
        r0 = reads;
        drain_en = 1'b1;
        push_words(200, 1'b1, 0);
        for (int i = 0; i < 4000 && delivered < d0 + 200; i++) begin
            cycle();
            ifc.out_ready = 1'($urandom_range(0, 1));
            empty_mask    = ($urandom_range(0, 3) == 0);
            drain_en      = ($urandom_range(0, 7) != 0);
        end
        ifc.out_ready = 1'b1;
        empty_mask = 1'b0;
        drain_en = 1'b1;
        chk("random_delivered", delivered - d0, 200);
        chk("random_reads", reads - r0, 200);
        repeat (3) cycle();
        @(negedge clk);
        chk("end_busy", int'(busy), 0);
        chk("end_exp_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
